// File: rtl/iterative_shifter.sv
// Multi-cycle ARM data-processing shifter: applies LSL/LSR/ASR/ROR/RRX to the
// selected shiftee, STEP bits per cycle, and delivers shifter_operand plus carry.
module iterative_shifter #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] shiftee,
  input  logic [1:0]  shift_type,
  input  logic        rrx,
  input  logic [7:0]  shift_amount,
  input  logic        carry_in,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;
  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state_r;
  logic [31:0] result_r;
  logic        carry_r;
  logic        done_r;
  logic        ready_r;
  logic [5:0]  remaining_r;
  logic [1:0]  type_r;

  logic        accept_s;
  logic [5:0]  count_s;
  logic [31:0] step_val_s;
  logic        step_carry_s;
  logic [5:0]  step_k_s;
  logic        last_step_s;

  // Effective iteration count; the serial shifter then reproduces every ARM
  // boundary case (by 32, beyond 32, rotate by multiples of 32) on its own.
  function automatic logic [5:0] eff_count(input logic [1:0] typ, input logic rrx_i,
                                           input logic [7:0] amt);
    logic [5:0] n;
    n = 6'd0;
    if (rrx_i) begin
      n = 6'd0;
    end else begin
      case (typ)
        T_LSL, T_LSR: n = (amt > 8'd33) ? 6'd33 : amt[5:0];
        T_ASR:        n = (amt > 8'd32) ? 6'd32 : amt[5:0];
        T_ROR: begin
          if (amt == 8'd0) begin
            n = 6'd0;
          end else if (amt[4:0] == 5'd0) begin
            n = 6'd32;
          end else begin
            n = {1'b0, amt[4:0]};
          end
        end
        default: n = 6'd0;
      endcase
    end
    return n;
  endfunction

  // One-bit shift; returns {bit shifted out, new value}.
  function automatic logic [32:0] shift_bit(input logic [1:0] typ, input logic [31:0] v);
    logic [32:0] r;
    r = {1'b0, v};
    case (typ)
      T_LSL:   r = {v[31], v[30:0], 1'b0};
      T_LSR:   r = {v[0], 1'b0, v[31:1]};
      T_ASR:   r = {v[0], v[31], v[31:1]};
      T_ROR:   r = {v[0], v[0], v[31:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  // Request acceptance and the effective count for the operands on the inputs.
  always_comb begin
    accept_s = start && (state_r != ST_SHIFT);
    count_s  = eff_count(shift_type, rrx, shift_amount);
  end

  // Up to STEP single-bit shifts of the working register, stopping at remaining.
  always_comb begin
    step_val_s   = result_r;
    step_carry_s = carry_r;
    for (int i = 0; i < STEP; i++) begin
      {step_carry_s, step_val_s} = (6'(i) < remaining_r) ? shift_bit(type_r, step_val_s)
                                                          : {step_carry_s, step_val_s};
    end
    step_k_s    = (remaining_r > STEP_W) ? STEP_W : remaining_r;
    last_step_s = (remaining_r <= STEP_W);
  end

  // Control FSM; result_r doubles as the working register during SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      result_r    <= 32'd0;
      carry_r     <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
      remaining_r <= 6'd0;
      type_r      <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            type_r <= shift_type;
            if (count_s == 6'd0) begin
              state_r     <= ST_DONE;
              done_r      <= 1'b1;
              ready_r     <= 1'b1;
              remaining_r <= 6'd0;
              if (rrx) begin
                result_r <= {carry_in, shiftee[31:1]};
                carry_r  <= shiftee[0];
              end else begin
                result_r <= shiftee;
                carry_r  <= carry_in;
              end
            end else begin
              state_r     <= ST_SHIFT;
              done_r      <= 1'b0;
              ready_r     <= 1'b0;
              remaining_r <= count_s;
              result_r    <= shiftee;
              carry_r     <= carry_in;
            end
          end else begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        ST_SHIFT: begin
          result_r    <= step_val_s;
          carry_r     <= step_carry_s;
          remaining_r <= remaining_r - step_k_s;
          if (last_step_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            ready_r <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          ready_r     <= 1'b1;
          remaining_r <= 6'd0;
        end
      endcase
    end
  end

  assign ready     = ready_r;
  assign done      = done_r;
  assign result    = result_r;
  assign carry_out = carry_r;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: directed vector table, random ops against an
// arithmetic ARM-shift model, plus reset/ignored-start/back-to-back sequences.
module tb_iterative_shifter;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] shiftee;
  logic [1:0]  shift_type;
  logic        rrx;
  logic [7:0]  shift_amount;
  logic        carry_in;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int cmp_count = 0;
  int err_count = 0;

  iterative_shifter #(.STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shiftee(shiftee),
    .shift_type(shift_type), .rrx(rrx), .shift_amount(shift_amount),
    .carry_in(carry_in), .ready(ready), .done(done), .result(result),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic        rrx;
    logic [7:0]  amt;
    logic [31:0] x;
    logic        cin;
    logic [31:0] exp_res;
    logic        exp_c;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ARM shifter semantics written directly from the architectural rules.
  function automatic logic [32:0] ref_shift(input logic [1:0] typ, input logic rx,
                                            input logic [7:0] amt, input logic [31:0] x,
                                            input logic cin);
    int a;
    int r;
    a = int'(amt);
    if (rx) return {x[0], cin, x[31:1]};
    if (a == 0) return {cin, x};
    case (typ)
      2'b00: begin
        if (a < 32) return {x[32 - a], x << a};
        if (a == 32) return {x[0], 32'd0};
        return 33'd0;
      end
      2'b01: begin
        if (a < 32) return {x[a - 1], x >> a};
        if (a == 32) return {x[31], 32'd0};
        return 33'd0;
      end
      2'b10: begin
        if (a < 32) return {x[a - 1], 32'($signed(x) >>> a)};
        return {x[31], {32{x[31]}}};
      end
      default: begin
        r = a % 32;
        if (r == 0) return {x[31], x};
        return {x[r - 1], (x >> r) | (x << (32 - r))};
      end
    endcase
  endfunction

  // Edges after the accepting edge until done is seen: ceil(N/STEP).
  function automatic int ref_latency(input logic [1:0] typ, input logic rx, input logic [7:0] amt);
    int a;
    int n;
    a = int'(amt);
    if (rx) n = 0;
    else if (typ == 2'b00 || typ == 2'b01) n = (a > 33) ? 33 : a;
    else if (typ == 2'b10) n = (a > 32) ? 32 : a;
    else if (a == 0) n = 0;
    else if (a % 32 == 0) n = 32;
    else n = a % 32;
    return (n + STEP - 1) / STEP;
  endfunction

  // Issue one op (accepted at the next rising edge), scramble inputs after
  // acceptance, and wait a bounded time for done.
  task automatic run_op(input logic [1:0] typ, input logic rx, input logic [7:0] amt,
                        input logic [31:0] x, input logic cin,
                        output logic [31:0] res, output logic c, output int lat);
    @(negedge clk);
    shift_type = typ; rrx = rx; shift_amount = amt; shiftee = x; carry_in = cin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    shiftee = $urandom; shift_amount = 8'($urandom); shift_type = 2'($urandom);
    rrx = 1'($urandom); carry_in = 1'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    c = carry_out;
  endtask

  task automatic do_op(input string name, input logic [1:0] typ, input logic rx,
                       input logic [7:0] amt, input logic [31:0] x, input logic cin,
                       input logic [31:0] exp_res, input logic exp_c, input int exp_lat);
    logic [31:0] res;
    logic c;
    int lat;
    run_op(typ, rx, amt, x, cin, res, c, lat);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_result"}, res, exp_res);
    check({name, "_carry"}, 32'(c), 32'(exp_c));
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_ready"}, 32'(ready), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [32:0] m;
    logic [7:0]  amt;
    logic [1:0]  typ;
    logic        rx;
    logic [31:0] x;
    logic        cin;
    logic [31:0] held_res;
    logic        held_c;
    int          done_seen;

    rst_n = 1'b0; start = 1'b0; shiftee = 32'd0; shift_type = 2'b00;
    rrx = 1'b0; shift_amount = 8'd0; carry_in = 1'b0;

    #12;
    check("reset_result", result, 32'd0);
    check("reset_carry", 32'(carry_out), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{2'b00, 1'b0, 8'd4,   32'h000000FF, 1'b0, 32'h00000FF0, 1'b0, 1});
    vecs.push_back('{2'b01, 1'b0, 8'd32,  32'h80000001, 1'b0, 32'h00000000, 1'b1, 8});
    vecs.push_back('{2'b01, 1'b0, 8'd40,  32'h80000001, 1'b0, 32'h00000000, 1'b0, 9});
    vecs.push_back('{2'b10, 1'b0, 8'd200, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1, 8});
    vecs.push_back('{2'b11, 1'b0, 8'd32,  32'h80000001, 1'b0, 32'h80000001, 1'b1, 8});
    vecs.push_back('{2'b11, 1'b0, 8'd4,   32'h00000012, 1'b0, 32'h20000001, 1'b0, 1});
    vecs.push_back('{2'b00, 1'b0, 8'd0,   32'h12345678, 1'b1, 32'h12345678, 1'b1, 0});
    vecs.push_back('{2'b01, 1'b1, 8'd77,  32'h00000003, 1'b1, 32'h80000001, 1'b1, 0});
    vecs.push_back('{2'b00, 1'b0, 8'd32,  32'h00000001, 1'b0, 32'h00000000, 1'b1, 8});
    vecs.push_back('{2'b00, 1'b0, 8'd33,  32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 9});
    vecs.push_back('{2'b10, 1'b0, 8'd31,  32'h40000000, 1'b0, 32'h00000000, 1'b1, 8});
    vecs.push_back('{2'b11, 1'b0, 8'd255, 32'h00000001, 1'b1, 32'h00000002, 1'b0, 8});
    vecs.push_back('{2'b01, 1'b0, 8'd1,   32'h00000003, 1'b0, 32'h00000001, 1'b1, 1});
    vecs.push_back('{2'b10, 1'b0, 8'd0,   32'h80000000, 1'b0, 32'h80000000, 1'b0, 0});

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].typ, vecs[i].rrx, vecs[i].amt, vecs[i].x,
            vecs[i].cin, vecs[i].exp_res, vecs[i].exp_c, vecs[i].exp_lat);
    end

    // Outputs must hold while idle.
    held_res = result;
    held_c = carry_out;
    repeat (3) @(posedge clk);
    #1;
    check("idle_result_hold", result, held_res);
    check("idle_carry_hold", 32'(carry_out), 32'(held_c));
    check("idle_done", 32'(done), 32'd0);
    check("idle_ready", 32'(ready), 32'd1);

    // Randomized ops against the model, with occasional idle gaps.
    for (int n = 0; n < 150; n++) begin
      typ = 2'($urandom);
      rx  = ($urandom_range(0, 7) == 0);
      amt = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      x   = $urandom;
      cin = 1'($urandom);
      m   = ref_shift(typ, rx, amt, x, cin);
      do_op($sformatf("rand%0d", n), typ, rx, amt, x, cin, m[31:0], m[32],
            ref_latency(typ, rx, amt));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        check($sformatf("rand%0d_idle_hold", n), result, m[31:0]);
      end
    end

    // Back-to-back: the start presented during DONE is accepted.
    do_op("b2b_a", 2'b00, 1'b0, 8'd4, 32'h0000000F, 1'b0, 32'h000000F0, 1'b0, 1);
    check("b2b_ready_in_done", 32'(ready), 32'd1);
    do_op("b2b_b", 2'b00, 1'b1, 8'd0, 32'h00000003, 1'b1, 32'h80000001, 1'b1, 0);
    do_op("b2b_c", 2'b01, 1'b0, 8'd8, 32'h0000FF00, 1'b0, 32'h000000FF, 1'b0, 2);

    // ROR 31, start pulse during SHIFT is ignored, then reset mid-SHIFT.
    @(negedge clk);
    shift_type = 2'b11; rrx = 1'b0; shift_amount = 8'd31; shiftee = 32'hDEADBEEF;
    carry_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort_busy_ready", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    shift_type = 2'b00; shift_amount = 8'd0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_start_done", 32'(done), 32'd0);
    check("ignored_start_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_result_after", result, 32'd0);

    // Normal operation resumes after the abort.
    do_op("post_abort", 2'b10, 1'b0, 8'd4, 32'h80000010, 1'b0, 32'hF8000001, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
